// File: rtl/dot_product_pkg.sv
// Shared parameters and width helper for the streaming dot-product engine.
package dot_product_pkg;

    localparam int unsigned DP_DATA_W = 8;
    localparam int unsigned DP_LEN    = 8;

    // Result width that cannot overflow for any LEN products of DATA_W operands.
    function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned len);
        if (len <= 1) begin
            return 2 * data_w + 1;
        end
        return 2 * data_w + int'($clog2(len));
    endfunction

endpackage

// File: rtl/dot_lane_sum.sv
// Combinational sum of LANES element-pair products, each extended to ACC_W.
module dot_lane_sum #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LANES  = 1,
    parameter int unsigned SIGNED = 0,
    parameter int unsigned ACC_W  = 19
) (
    input  logic [LANES*DATA_W-1:0] a,
    input  logic [LANES*DATA_W-1:0] b,
    output logic [ACC_W-1:0]        sum
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned EXT_W  = ACC_W - PROD_W;

    logic [ACC_W-1:0] ext [LANES];

    for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
        if (SIGNED != 0) begin : g_signed
            logic signed [PROD_W-1:0] prod;
            assign prod   = $signed(a[i*DATA_W +: DATA_W]) * $signed(b[i*DATA_W +: DATA_W]);
            assign ext[i] = {{EXT_W{prod[PROD_W-1]}}, prod};
        end else begin : g_unsigned
            logic [PROD_W-1:0] prod;
            assign prod   = a[i*DATA_W +: DATA_W] * b[i*DATA_W +: DATA_W];
            assign ext[i] = {{EXT_W{1'b0}}, prod};
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            sum = sum + ext[i];
        end
    end

endmodule

// File: rtl/dot_product_stream.sv
// Streaming dot-product engine: accumulates LEN element pairs, LANES per beat,
// and presents each result through a single-entry valid/ready output buffer.
module dot_product_stream
    import dot_product_pkg::*;
#(
    parameter int unsigned DATA_W = DP_DATA_W,
    parameter int unsigned LEN    = DP_LEN,
    parameter int unsigned LANES  = 1,
    parameter int unsigned SIGNED = 0,
    localparam int unsigned ACC_W = acc_width(DATA_W, LEN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_a,
    input  logic [LANES*DATA_W-1:0] in_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_result
);

    localparam int unsigned BEATS = LEN / LANES;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0] beat_cnt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] beat_sum;
    logic [ACC_W-1:0] acc_next;
    logic             last_beat;
    logic             accept;

    dot_lane_sum #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .SIGNED (SIGNED),
        .ACC_W  (ACC_W)
    ) u_lane_sum (
        .a   (in_a),
        .b   (in_b),
        .sum (beat_sum)
    );

    // Only the final beat can stall, and only while the buffered result is unconsumed.
    always_comb begin
        last_beat = (beat_cnt == LAST_CNT);
        in_ready  = !(last_beat && out_valid && !out_ready);
        accept    = in_valid && in_ready;
        acc_next  = (beat_cnt == '0) ? beat_sum : acc + beat_sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt   <= '0;
            acc        <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
        end else begin
            if (accept) begin
                acc      <= acc_next;
                beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
            end
            // A new result replaces a consumed one in the same cycle without a bubble.
            if (accept && last_beat) begin
                out_result <= acc_next;
                out_valid  <= 1'b1;
            end else if (out_ready) begin
                out_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dot_product_stream.sv
// Scoreboard bench for dot_product_stream: an unsigned 2-lane and a signed 1-lane instance.
module tb_dot_product_stream;

    localparam int unsigned DW  = 8;
    localparam int unsigned LEN = 8;
    localparam int unsigned AW  = dot_product_pkg::acc_width(DW, LEN);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          u_in_valid = 1'b0, u_in_ready, u_out_valid, u_out_ready = 1'b1;
    logic [2*DW-1:0] u_in_a = '0, u_in_b = '0;
    logic [AW-1:0] u_out_result;
    logic          s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b1;
    logic [DW-1:0] s_in_a = '0, s_in_b = '0;
    logic [AW-1:0] s_out_result;

    dot_product_stream #(.DATA_W(DW), .LEN(LEN), .LANES(2), .SIGNED(0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(u_in_valid), .in_ready(u_in_ready),
        .in_a(u_in_a), .in_b(u_in_b), .out_valid(u_out_valid),
        .out_ready(u_out_ready), .out_result(u_out_result)
    );

    dot_product_stream #(.DATA_W(DW), .LEN(LEN), .LANES(1), .SIGNED(1)) s_dut (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_result(s_out_result)
    );

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] u_q[$];
    logic [AW-1:0] s_q[$];
    bit u_rand = 1'b0, s_rand = 1'b0;
    bit u_force = 1'b1, s_force = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer dot product, truncated to the result width.
    function automatic logic [AW-1:0] ref_dot(input int ia[LEN], input int ib[LEN]);
        longint s = 0;
        for (int i = 0; i < int'(LEN); i++) s += longint'(ia[i]) * longint'(ib[i]);
        return AW'(s);
    endfunction

    // out_ready is applied 2 time units after each rising edge.
    always begin
        @(posedge clk);
        #2;
        u_out_ready = u_rand ? ($urandom_range(0, 3) != 0) : u_force;
        s_out_ready = s_rand ? ($urandom_range(0, 2) != 0) : s_force;
    end

    // Called and returns at posedge+1; presents one beat until accepted.
    task automatic send_beat(input bit sel, input logic [2*DW-1:0] a, input logic [2*DW-1:0] b,
                             output bit ok);
        ok = 1'b0;
        if (sel) begin s_in_a = a[DW-1:0]; s_in_b = b[DW-1:0]; s_in_valid = 1'b1; end
        else     begin u_in_a = a;         u_in_b = b;         u_in_valid = 1'b1; end
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            if (sel ? s_in_ready : u_in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (sel) s_in_valid = 1'b0; else u_in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout sel=%0d actual=no_accept required=accept", sel);
        end
    endtask

    task automatic send_vec(input bit sel, input logic [DW-1:0] va[LEN], input logic [DW-1:0] vb[LEN],
                            input int gap);
        int lanes = sel ? 1 : 2;
        int beats = int'(LEN) / lanes;
        logic [2*DW-1:0] pa, pb;
        int ia[LEN], ib[LEN];
        bit ok;
        for (int k = 0; k < beats; k++) begin
            pa = '0;
            pb = '0;
            for (int l = 0; l < lanes; l++) begin
                pa[l*DW +: DW] = va[k*lanes + l];
                pb[l*DW +: DW] = vb[k*lanes + l];
            end
            send_beat(sel, pa, pb, ok);
            if (!ok) return;
            if (k != beats - 1) repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
        end
        for (int i = 0; i < int'(LEN); i++) begin
            ia[i] = sel ? int'($signed(va[i])) : int'(va[i]);
            ib[i] = sel ? int'($signed(vb[i])) : int'(vb[i]);
        end
        if (sel) s_q.push_back(ref_dot(ia, ib)); else u_q.push_back(ref_dot(ia, ib));
    endtask

    logic [AW-1:0] u_hold, s_hold;
    bit u_hold_v = 1'b0, s_hold_v = 1'b0;

    always @(negedge clk) begin
        if (rst) u_hold_v = 1'b0;
        else begin
            if (u_hold_v) begin
                check("u_hold_valid", 32'(u_out_valid), 32'(1));
                check("u_hold_stable", 32'(u_out_result), 32'(u_hold));
            end
            if (u_out_valid && u_out_ready) begin
                if (u_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL u_result actual=%0h required=no_result", u_out_result);
                end else check("u_result", 32'(u_out_result), 32'(u_q.pop_front()));
            end
            u_hold_v = u_out_valid && !u_out_ready;
            u_hold   = u_out_result;
        end
    end

    always @(negedge clk) begin
        if (rst) s_hold_v = 1'b0;
        else begin
            if (s_hold_v) begin
                check("s_hold_valid", 32'(s_out_valid), 32'(1));
                check("s_hold_stable", 32'(s_out_result), 32'(s_hold));
            end
            if (s_out_valid && s_out_ready) begin
                if (s_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL s_result actual=%0h required=no_result", s_out_result);
                end else check("s_result", 32'(s_out_result), 32'(s_q.pop_front()));
            end
            s_hold_v = s_out_valid && !s_out_ready;
            s_hold   = s_out_result;
        end
    end

    logic [DW-1:0] va[LEN], vb[LEN];
    logic [AW-1:0] v2_exp;
    bit ok;
    int ia[LEN], ib[LEN];

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_u_valid", 32'(u_out_valid), 32'(0));
        check("rst_u_result", 32'(u_out_result), 32'(0));
        check("rst_s_valid", 32'(s_out_valid), 32'(0));
        check("rst_s_result", 32'(s_out_result), 32'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_u_ready", 32'(u_in_ready), 32'(1));
        check("rst_s_ready", 32'(s_in_ready), 32'(1));
        @(posedge clk); #1;

        // Ramp 1..8 against all ones, then the unsigned maximum.
        for (int i = 0; i < int'(LEN); i++) begin va[i] = 8'(i + 1); vb[i] = 8'd1; end
        send_vec(1'b0, va, vb, 0);
        @(negedge clk);
        check("ramp_valid", 32'(u_out_valid), 32'(1));
        check("ramp_result", 32'(u_out_result), 32'd36);
        @(negedge clk);
        check("ramp_single_pulse", 32'(u_out_valid), 32'(0));
        @(posedge clk); #1;
        for (int i = 0; i < int'(LEN); i++) begin va[i] = 8'hFF; vb[i] = 8'hFF; end
        send_vec(1'b0, va, vb, 0);
        @(negedge clk);
        check("umax_result", 32'(u_out_result), 32'h7F008);
        @(posedge clk); #1;

        // Signed corner values.
        for (int i = 0; i < int'(LEN); i++) begin va[i] = 8'hFF; vb[i] = 8'h01; end
        send_vec(1'b1, va, vb, 0);
        @(negedge clk);
        check("sneg_result", 32'(s_out_result), 32'h7FFF8);
        @(posedge clk); #1;
        for (int i = 0; i < int'(LEN); i++) begin va[i] = 8'h80; vb[i] = 8'h80; end
        send_vec(1'b1, va, vb, 0);
        @(negedge clk);
        check("smin_result", 32'(s_out_result), 32'd131072);
        @(posedge clk); #1;

        // Back-pressure: vector 1 held, vector 2 stalls only on its last beat.
        u_force = 1'b0;
        for (int i = 0; i < int'(LEN); i++) begin va[i] = 8'($urandom); vb[i] = 8'($urandom); end
        send_vec(1'b0, va, vb, 0);
        for (int i = 0; i < int'(LEN); i++) begin
            va[i] = 8'($urandom); vb[i] = 8'($urandom);
            ia[i] = int'(va[i]); ib[i] = int'(vb[i]);
        end
        v2_exp = ref_dot(ia, ib);
        for (int k = 0; k < 3; k++) begin
            u_in_a = {va[2*k+1], va[2*k]}; u_in_b = {vb[2*k+1], vb[2*k]}; u_in_valid = 1'b1;
            @(negedge clk);
            check("bp_ready", 32'(u_in_ready), 32'(1));
            @(posedge clk); #1;
        end
        u_in_a = {va[7], va[6]}; u_in_b = {vb[7], vb[6]};
        repeat (3) begin
            @(negedge clk);
            check("bp_stall", 32'(u_in_ready), 32'(0));
            @(posedge clk); #1;
        end
        u_force = 1'b1;
        @(negedge clk);
        check("bp_release", 32'(u_in_ready), 32'(1));
        u_q.push_back(v2_exp);
        @(posedge clk); #1 u_in_valid = 1'b0;
        @(negedge clk);
        check("simul_valid", 32'(u_out_valid), 32'(1));
        check("simul_result", 32'(u_out_result), 32'(v2_exp));
        @(posedge clk); #1;

        // Reset with a pending result and a partial vector in flight.
        u_force = 1'b0;
        for (int i = 0; i < int'(LEN); i++) begin va[i] = 8'($urandom); vb[i] = 8'($urandom); end
        send_vec(1'b0, va, vb, 0);
        send_beat(1'b0, 16'h0505, 16'h0707, ok);
        send_beat(1'b0, 16'h0909, 16'h0B0B, ok);
        rst = 1'b1;
        @(posedge clk); #1;
        u_q.delete();
        repeat (2) begin
            @(negedge clk);
            check("rst_mid_valid", 32'(u_out_valid), 32'(0));
            @(posedge clk); #1;
        end
        rst = 1'b0;
        u_force = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", 32'(u_in_ready), 32'(1));
        @(posedge clk); #1;
        for (int i = 0; i < int'(LEN); i++) begin va[i] = 8'd2; vb[i] = 8'd3; end
        send_vec(1'b0, va, vb, 0);
        @(negedge clk);
        check("rst_fresh_valid", 32'(u_out_valid), 32'(1));
        check("rst_fresh_result", 32'(u_out_result), 32'd48);
        @(posedge clk); #1;

        // Random traffic on both instances with random gaps and back-pressure.
        u_rand = 1'b1;
        s_rand = 1'b1;
        fork
            begin
                logic [DW-1:0] ra[LEN], rb[LEN];
                for (int n = 0; n < 30; n++) begin
                    for (int i = 0; i < int'(LEN); i++) begin ra[i] = 8'($urandom); rb[i] = 8'($urandom); end
                    send_vec(1'b0, ra, rb, 2);
                end
            end
            begin
                logic [DW-1:0] qa[LEN], qb[LEN];
                for (int n = 0; n < 30; n++) begin
                    for (int i = 0; i < int'(LEN); i++) begin qa[i] = 8'($urandom); qb[i] = 8'($urandom); end
                    send_vec(1'b1, qa, qb, 3);
                end
            end
        join
        u_rand = 1'b0;
        s_rand = 1'b0;
        for (int t = 0; t < 50 && (u_q.size() != 0 || s_q.size() != 0); t++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("drain_u", 32'(u_q.size()), 32'(0));
        check("drain_s", 32'(s_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
